// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin fetch/load arbiter for one pipelined memory read port,
//            with a fixed-latency tag pipeline that routes data back to its owner.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  input  logic          i_flush,
  output logic          i_ready,
  output logic [AW-1:0] i_raddr_out,
  output logic [DW-1:0] i_data_out,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  output logic          d_gnt,
  output logic          d_ready,
  output logic [AW-1:0] d_raddr_out,
  output logic [DW-1:0] d_data_out,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          proto_err
);

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  logic                r_last_gnt;
  logic [LATENCY:0]    r_tag_v;
  logic [LATENCY:0]    r_tag_side;
  logic [AW-1:0]       r_tag_addr [LATENCY+1];

  logic                w_xfer;
  logic                w_xfer_side;
  logic [AW-1:0]       w_xfer_addr;
  logic                w_ret_v;

  assign i_gnt = rst_n & i_req & ~i_flush & (~d_req | (r_last_gnt == SIDE_D));
  assign d_gnt = rst_n & d_req & (~i_req | i_flush | (r_last_gnt == SIDE_I));

  assign w_xfer      = i_gnt | d_gnt;
  assign w_xfer_side = d_gnt ? SIDE_D : SIDE_I;
  assign w_xfer_addr = d_gnt ? d_addr : i_addr;

  // A fetch tag retiring on the same edge as a flush counts as already squashed.
  assign w_ret_v = r_tag_v[LATENCY] & ~(i_flush & (r_tag_side[LATENCY] == SIDE_I));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_gnt  <= SIDE_D;
      r_tag_v     <= '0;
      r_tag_side  <= '0;
      mem_re      <= 1'b0;
      mem_raddr   <= '0;
      i_ready     <= 1'b0;
      i_raddr_out <= '0;
      i_data_out  <= '0;
      d_ready     <= 1'b0;
      d_raddr_out <= '0;
      d_data_out  <= '0;
      proto_err   <= 1'b0;
    end else begin
      mem_re <= w_xfer;
      if (w_xfer) begin
        mem_raddr  <= w_xfer_addr;
        r_last_gnt <= w_xfer_side;
      end

      r_tag_v[0]    <= w_xfer;
      r_tag_side[0] <= w_xfer_side;
      r_tag_addr[0] <= w_xfer_addr;
      for (int k = 1; k <= LATENCY; k++) begin
        r_tag_v[k]    <= r_tag_v[k-1] & ~(i_flush & (r_tag_side[k-1] == SIDE_I));
        r_tag_side[k] <= r_tag_side[k-1];
        r_tag_addr[k] <= r_tag_addr[k-1];
      end

      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (w_ret_v && mem_rvalid) begin
        if (r_tag_side[LATENCY] == SIDE_D) begin
          d_ready     <= 1'b1;
          d_raddr_out <= r_tag_addr[LATENCY];
          d_data_out  <= mem_rdata;
        end else begin
          i_ready     <= 1'b1;
          i_raddr_out <= r_tag_addr[LATENCY];
          i_data_out  <= mem_rdata;
        end
      end

      // Stray data or a missing return both break the fixed-latency contract.
      if (mem_rvalid != w_ret_v) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed and randomized bench for mem_arbiter against an in-flight
//            read list model; second instance exercises LATENCY=1 streaming.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int LAT = 2;

  typedef struct {
    bit          side;
    logic [15:0] addr;
    int          due;
    bit          live;
  } tag_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } mem_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_flush, d_req, mem_rvalid;
  logic [15:0] i_addr, d_addr, mem_rdata;
  logic        i_gnt, i_ready, d_gnt, d_ready, mem_re, proto_err;
  logic [15:0] i_raddr_out, i_data_out, d_raddr_out, d_data_out, mem_raddr;

  logic        d_req2, rv2;
  logic [15:0] d_addr2, rd2;
  logic        i_gnt2, i_ready2, d_gnt2, d_ready2, mem_re2, proto_err2;
  logic [15:0] i_raddr2, i_data2, d_raddr2, d_data2, mem_raddr2;

  int          checks = 0;
  int          passed = 0;
  int          cyc    = 0;
  tag_t        tags[$];
  mem_t        memq[$];
  bit          m_last_d, g_i, g_d, withhold, use_beef;
  bit          sv_re2;
  logic [15:0] sv_addr2;
  logic        e_re, e_ir, e_dr, e_err;
  logic [15:0] e_raddr, e_iaddr, e_idata, e_daddr, e_ddata;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(LAT), .AW(16), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_flush(i_flush),
    .i_ready(i_ready), .i_raddr_out(i_raddr_out), .i_data_out(i_data_out),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
    .d_ready(d_ready), .d_raddr_out(d_raddr_out), .d_data_out(d_data_out),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  mem_arbiter #(.LATENCY(1), .AW(16), .DW(16)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(1'b0), .i_addr(16'h0000), .i_gnt(i_gnt2), .i_flush(1'b0),
    .i_ready(i_ready2), .i_raddr_out(i_raddr2), .i_data_out(i_data2),
    .d_req(d_req2), .d_addr(d_addr2), .d_gnt(d_gnt2),
    .d_ready(d_ready2), .d_raddr_out(d_raddr2), .d_data_out(d_data2),
    .mem_re(mem_re2), .mem_raddr(mem_raddr2), .mem_rvalid(rv2),
    .mem_rdata(rd2), .proto_err(proto_err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: check grants, advance the model across the edge, check outputs,
  // then present memory return data for the new cycle.
  task automatic tick();
    bit          ei, ed, found, live, side;
    logic [15:0] addr;
    #1;
    ei = rst_n && i_req && !i_flush;
    ed = rst_n && d_req;
    if (ei && ed) begin
      g_i = m_last_d;
      g_d = !m_last_d;
    end else begin
      g_i = ei;
      g_d = ed;
    end
    chk("i_gnt", i_gnt, g_i);
    chk("d_gnt", d_gnt, g_d);

    @(posedge clk);
    if (!rst_n) begin
      tags.delete();
      m_last_d = 1'b1;
      e_re = 0; e_raddr = 0; e_ir = 0; e_iaddr = 0; e_idata = 0;
      e_dr = 0; e_daddr = 0; e_ddata = 0; e_err = 0;
    end else begin
      found = 0; live = 0; side = 0; addr = 0;
      foreach (tags[k]) begin
        if (i_flush && tags[k].side == 1'b0) tags[k].live = 1'b0;
        if (tags[k].due == cyc) begin
          found = 1; live = tags[k].live; side = tags[k].side; addr = tags[k].addr;
        end
      end
      while (tags.size() > 0 && tags[0].due <= cyc) void'(tags.pop_front());
      e_ir = 0;
      e_dr = 0;
      if (found && live && mem_rvalid) begin
        if (side) begin e_dr = 1; e_daddr = addr; e_ddata = mem_rdata; end
        else      begin e_ir = 1; e_iaddr = addr; e_idata = mem_rdata; end
      end
      if ((mem_rvalid && !(found && live)) || (found && live && !mem_rvalid)) e_err = 1;
      if (g_i || g_d) begin
        addr = g_d ? d_addr : i_addr;
        tags.push_back('{side: g_d, addr: addr, due: cyc + 1 + LAT, live: 1'b1});
        if (!withhold)
          memq.push_back('{due: cyc + 1 + LAT, data: use_beef ? 16'hBEEF : 16'($urandom)});
        e_re = 1; e_raddr = addr; m_last_d = g_d;
      end else begin
        e_re = 0;
      end
    end
    cyc++;

    #1;
    chk("mem_re", mem_re, e_re);
    chk("mem_raddr", mem_raddr, e_raddr);
    chk("i_ready", i_ready, e_ir);
    chk("i_raddr_out", i_raddr_out, e_iaddr);
    chk("i_data_out", i_data_out, e_idata);
    chk("d_ready", d_ready, e_dr);
    chk("d_raddr_out", d_raddr_out, e_daddr);
    chk("d_data_out", d_data_out, e_ddata);
    chk("proto_err", proto_err, e_err);

    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);
    foreach (memq[k]) if (memq[k].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = memq[k].data;
    end
    while (memq.size() > 0 && memq[0].due <= cyc) void'(memq.pop_front());

    rv2      = sv_re2;
    rd2      = sv_addr2 ^ 16'h5A5A;
    sv_re2   = mem_re2;
    sv_addr2 = mem_raddr2;
  endtask

  initial begin
    rst_n = 0; i_req = 0; i_flush = 0; d_req = 0; i_addr = 0; d_addr = 0;
    mem_rvalid = 0; mem_rdata = 0; d_req2 = 0; d_addr2 = 0; rv2 = 0; rd2 = 0;
    sv_re2 = 0; sv_addr2 = 0; withhold = 0; use_beef = 0; m_last_d = 1;
    repeat (2) tick();
    rst_n = 1;

    // Continuous contention straight out of reset: I, D, I, D ...
    i_req = 1; i_addr = 16'h0100; d_req = 1; d_addr = 16'h0200;
    repeat (8) tick();
    i_req = 0; d_req = 0;
    repeat (6) tick();

    // Single fetch with known data.
    i_req = 1; i_addr = 16'h0010; use_beef = 1;
    tick();
    i_req = 0; use_beef = 0;
    repeat (5) tick();

    // Two fetches squashed by a flush; load granted during the flush.
    i_req = 1; i_addr = 16'h0004; tick();
    i_addr = 16'h0005; tick();
    i_req = 0; i_flush = 1; d_req = 1; d_addr = 16'h0300; tick();
    i_flush = 0; d_req = 0;
    repeat (6) tick();
    chk("t3_stray_err", proto_err, 1'b1);
    rst_n = 0; repeat (4) tick(); rst_n = 1;

    // Memory withholds a load return.
    withhold = 1; d_req = 1; d_addr = 16'h0400; tick();
    withhold = 0; d_req = 0;
    repeat (5) tick();
    chk("t4_missing_err", proto_err, 1'b1);

    // Reset while two reads are in flight, then a tie.
    i_req = 1; i_addr = 16'h0500; tick();
    i_req = 0; d_req = 1; d_addr = 16'h0600; tick();
    rst_n = 0; i_req = 1; i_addr = 16'h0700; d_req = 1; d_addr = 16'h0800;
    tick();
    chk("t5_mem_re", mem_re, 1'b0);
    chk("t5_err", proto_err, 1'b0);
    rst_n = 1;
    #1 chk("t5_tie_i", i_gnt, 1'b1);
    tick();
    i_req = 0; tick();
    d_req = 0;
    repeat (6) tick();
    rst_n = 0; repeat (5) tick(); rst_n = 1;

    // Randomized traffic; requesters hold until granted.
    for (int n = 0; n < 300; n++) begin
      if (!i_req || g_i) begin i_req = ($urandom_range(0, 3) != 0); i_addr = 16'($urandom); end
      if (!d_req || g_d) begin d_req = ($urandom_range(0, 3) != 0); d_addr = 16'($urandom); end
      i_flush = ($urandom_range(0, 15) == 0);
      tick();
    end
    i_req = 0; d_req = 0; i_flush = 0;
    repeat (6) tick();

    // LATENCY=1 instance: four back-to-back loads.
    for (int j = 0; j < 8; j++) begin
      d_req2 = (j < 4); d_addr2 = 16'(j);
      #1;
      if (j < 4) chk("t6_gnt", d_gnt2, 1'b1);
      tick();
      chk("t6_ready", d_ready2, (j >= 2 && j <= 5));
      if (j >= 2 && j <= 5) begin
        chk("t6_raddr", d_raddr2, 16'(j - 2));
        chk("t6_data", d_data2, 16'(j - 2) ^ 16'h5A5A);
      end
    end
    chk("t6_err", proto_err2, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single pipelined memory read port between instruction fetch (I) and data loads (D).
- Round-robin arbitration, one transfer per cycle. Each issued read is tagged with its requester and address in a fixed-latency tag pipeline. Returned data is routed to the owning requester.
- Supports a fetch flush on branch redirect. Sits between fetch / load unit and memcontr.

Parameters:
- LATENCY, 2: cycles from mem_re high to mem_rvalid high for that read; legal range 1..8.
- AW, 16: address width.
- DW, 16: data width.

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  synchronous active-low reset.
- i_req  in  1  fetch read request; held with i_addr until transferred.
- i_addr  in  AW  fetch address.
- i_gnt  out  1  combinational grant to fetch.
- i_flush  in  1  squash pending and in-flight fetch reads.
- i_ready  out  1  fetch response valid, one-cycle pulse.
- i_raddr_out  out  AW  address of the fetch response.
- i_data_out  out  DW  fetch response data.
- d_req  in  1  load read request.
- d_addr  in  AW  load address.
- d_gnt  out  1  combinational grant to load.
- d_ready  out  1  load response valid pulse.
- d_raddr_out  out  AW  address of the load response.
- d_data_out  out  DW  load response data.
- mem_re  out  1  registered memory read enable.
- mem_raddr  out  AW  registered memory read address.
- mem_rvalid  in  1  memory data valid, exactly LATENCY cycles after mem_re.
- mem_rdata  in  DW  memory read data.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n low at posedge): all tag valids cleared; mem_re, i_ready, d_ready, proto_err = 0; address/data outputs = 0; last_gnt = D, so I wins the first tie.
- Grant (combinational):
  - i_gnt = i_req & ~i_flush & (~d_req | last_gnt==D).
  - d_gnt = d_req & (~i_req | i_flush | last_gnt==I).
  - At most one grant is high. While rst_n is low, both grants are 0.
- Transfer: at the posedge where req & gnt. Requester may change req/addr from the next cycle. At the transfer edge:
  - mem_re <= 1, mem_raddr <= the granted address.
  - last_gnt <= the granted side.
  - tag {valid=1, side, addr} enters stage 0 of the tag pipeline.
- No transfer at an edge: mem_re <= 0; a tag with valid=0 enters. Tag pipeline shifts every cycle.
- Retirement: the tag issued LATENCY cycles before the current cycle is retired while mem_rvalid is sampled.
  - Tag valid & mem_rvalid: at the next edge, the owning side's ready <= 1, raddr_out <= tag addr, data_out <= mem_rdata. The other side's ready <= 0.
  - Response latency: transfer edge t → mem_re high in cycle t+1 → ready high in cycle t+1+LATENCY+1.
- i_flush high at an edge:
  - Every tag with side=I (all stages, including the retiring one) is cleared.
  - i_ready <= 0 at that edge.
  - No I transfer occurs; D may transfer in the same cycle.
- Errors (both set proto_err=1, sticky until reset, and produce no response):
  - mem_rvalid high with the retiring tag invalid, including flushed or pre-reset reads.
  - Retiring tag valid (not flushed) with mem_rvalid low.
- Back-to-back transfers are allowed every cycle. Round robin guarantees a waiting requester is served within 2 cycles.
- Reset mid-operation: in-flight reads are abandoned. A stale mem_rvalid after reset sets proto_err.

Test Plan:
1. LATENCY=2, i_req=1, i_addr=0x0010, d_req=0, memory returns 0xBEEF → i_gnt high; mem_re=1/mem_raddr=0x0010 in the following cycle; i_ready=1, i_raddr_out=0x0010, i_data_out=0xBEEF three cycles after mem_re; d_ready stays 0.
2. i_req and d_req held continuously from reset (addrs 0x0100, 0x0200) → grants alternate I,D,I,D; mem_raddr sequence 0x0100,0x0200,0x0100,...; responses return in the same order to the matching side.
3. I reads to 0x0004 and 0x0005 in flight; i_flush pulsed one cycle before the first mem_rvalid → no i_ready for either; d_req during the flush cycle is granted; proto_err sets (stray rvalid).
4. mem_rvalid withheld for an issued D read → d_ready never asserts; proto_err=1 and stays 1 until rst_n low.
5. rst_n low for one cycle while two reads are in flight → mem_re=0, i_ready=d_ready=proto_err=0 after that edge; first post-reset tie grants I.
6. LATENCY=1 instance: a D read every cycle for 4 cycles (0x0, 0x1, 0x2, 0x3) → d_ready high 4 consecutive cycles with matching d_raddr_out.
